// File: rtl/execute_stage_pipe.sv
// Execute stage: operand forwarding, saturating ALU, iterative shift-add
// multiplier with stall handshake, and the X/M pipeline register.
module execute_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de_valid,
    input  logic [3:0]        de_opcode,
    input  logic [REG_AW-1:0] de_rs,
    input  logic [REG_AW-1:0] de_rt,
    input  logic [REG_AW-1:0] de_rd,
    input  logic [DATA_W-1:0] de_reg1,
    input  logic [DATA_W-1:0] de_reg2,
    input  logic [DATA_W-1:0] de_imm,
    input  logic              de_alu_src,
    input  logic              de_reg_write,
    input  logic              de_mem_op,
    input  logic              flush,
    input  logic              mw_reg_write,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              xm_valid,
    output logic [DATA_W-1:0] xm_result,
    output logic [REG_AW-1:0] xm_rd,
    output logic              xm_reg_write,
    output logic [FLAG_W-1:0] flags
);

    localparam int AMT_W = $clog2(DATA_W);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ADDR_MASK = {{(DATA_W-1){1'b1}}, 1'b0};
    localparam logic [AMT_W-1:0]  CNT_LAST  = AMT_W'(DATA_W - 1);
    // flag vector layout {Z,V,N}
    localparam int FZ = 2;
    localparam int FV = 1;

    typedef enum logic {IDLE, BUSY} state_t;

    // Signed add/subtract clamped to the representable range; MSB of the
    // return value is the saturation indicator.
    function automatic logic [DATA_W:0] sat_addsub(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b,
                                                   input logic                     sub);
        logic [DATA_W:0] s;
        s = sub ? ({a[DATA_W-1], a} - {b[DATA_W-1], b})
                : ({a[DATA_W-1], a} + {b[DATA_W-1], b});
        if (s[DATA_W] != s[DATA_W-1])
            return {1'b1, (s[DATA_W] ? SAT_MIN : SAT_MAX)};
        return {1'b0, s[DATA_W-1:0]};
    endfunction

    state_t                   state, state_nxt;
    logic                     is_mul, mul_accept, mul_done, issue;
    logic                     x2x_a, m2x_a, x2x_b, m2x_b;
    logic signed [DATA_W-1:0] fwd_a, fwd_b, op_a, op_b;
    logic [3:0]               eff_op;
    logic [DATA_W-1:0]        alu_res;
    logic [DATA_W:0]          sat_r;
    logic [2*DATA_W-1:0]      ror_dbl;
    logic [AMT_W-1:0]         amt;
    logic [FLAG_W-1:0]        alu_flags;
    logic                     alu_upd;
    logic [DATA_W-1:0]        mul_a_p0, mul_b_p0, mul_acc_p0, acc_step;
    logic [AMT_W-1:0]         mul_cnt;
    logic [REG_AW-1:0]        mul_rd_p0;
    logic                     mul_rw_p0;

    assign is_mul   = de_valid && !de_mem_op && (de_opcode == OP_MUL);
    assign issue    = de_valid && !stall && !flush;
    assign acc_step = mul_acc_p0 + (mul_b_p0[0] ? mul_a_p0 : '0);

    // Operand selection: X2X beats M2X, register 0 never forwards.
    always_comb begin
        x2x_a  = xm_reg_write && (xm_rd != '0) && (xm_rd == de_rs);
        m2x_a  = mw_reg_write && (mw_rd != '0) && (mw_rd == de_rs);
        x2x_b  = xm_reg_write && (xm_rd != '0) && (xm_rd == de_rt);
        m2x_b  = mw_reg_write && (mw_rd != '0) && (mw_rd == de_rt);
        fwd_a  = x2x_a ? xm_result : (m2x_a ? wb_data : de_reg1);
        fwd_b  = x2x_b ? xm_result : (m2x_b ? wb_data : de_reg2);
        op_a   = de_mem_op ? (fwd_a & ADDR_MASK) : fwd_a;
        op_b   = de_alu_src ? de_imm : fwd_b;
        eff_op = de_mem_op ? OP_ADD : de_opcode;
    end

    // Single-cycle ALU result and the flag vector it would produce.
    always_comb begin
        alu_res   = op_b;
        alu_flags = flags;
        alu_upd   = 1'b0;
        sat_r     = '0;
        amt       = op_b[AMT_W-1:0];
        ror_dbl   = '0;
        case (eff_op)
            OP_ADD, OP_SUB: begin
                if (de_mem_op) begin
                    alu_res = op_a + op_b;
                end else begin
                    sat_r     = sat_addsub(op_a, op_b, eff_op == OP_SUB);
                    alu_res   = sat_r[DATA_W-1:0];
                    alu_flags = {~|alu_res, sat_r[DATA_W], alu_res[DATA_W-1]};
                    alu_upd   = 1'b1;
                end
            end
            OP_XOR: begin
                alu_res       = op_a ^ op_b;
                alu_flags[FZ] = ~|alu_res;
                alu_upd       = 1'b1;
            end
            OP_SLL: begin
                alu_res       = op_a << amt;
                alu_flags[FZ] = ~|alu_res;
                alu_upd       = 1'b1;
            end
            OP_SRA: begin
                alu_res       = op_a >>> amt;
                alu_flags[FZ] = ~|alu_res;
                alu_upd       = 1'b1;
            end
            OP_ROR: begin
                ror_dbl       = {op_a, op_a} >> amt;
                alu_res       = ror_dbl[DATA_W-1:0];
                alu_flags[FZ] = ~|alu_res;
                alu_upd       = 1'b1;
            end
            default: ;
        endcase
    end

    // Multiplier FSM next state; stall covers the accept cycle and all of BUSY.
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        mul_accept = 1'b0;
        mul_done   = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul && !flush) begin
                    stall      = 1'b1;
                    mul_accept = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mul_cnt == CNT_LAST) begin
                    mul_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Iteration counter: cleared on accept, one step per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                mul_cnt <= '0;
        else if (mul_accept)       mul_cnt <= '0;
        else if (state == BUSY)    mul_cnt <= mul_cnt + 1'b1;
    end

    // Shift-add datapath: latch operands on accept, then one partial product per cycle.
    always_ff @(posedge clk) begin
        if (mul_accept) begin
            mul_a_p0   <= op_a;
            mul_b_p0   <= op_b;
            mul_acc_p0 <= '0;
            mul_rd_p0  <= de_rd;
            mul_rw_p0  <= de_reg_write;
        end else if (state == BUSY) begin
            mul_acc_p0 <= acc_step;
            mul_a_p0   <= mul_a_p0 << 1;
            mul_b_p0   <= mul_b_p0 >> 1;
        end
    end

    // X/M register: flush bubble, multiplier completion, single-cycle issue, or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xm_valid     <= 1'b0;
            xm_result    <= '0;
            xm_rd        <= '0;
            xm_reg_write <= 1'b0;
            flags        <= '0;
        end else if (flush) begin
            xm_valid     <= 1'b0;
            xm_reg_write <= 1'b0;
        end else if (mul_done) begin
            xm_valid     <= 1'b1;
            xm_result    <= acc_step;
            xm_rd        <= mul_rd_p0;
            xm_reg_write <= mul_rw_p0;
            flags        <= {~|acc_step, flags[FV], acc_step[DATA_W-1]};
        end else if (issue) begin
            xm_valid     <= 1'b1;
            xm_result    <= alu_res;
            xm_rd        <= de_rd;
            xm_reg_write <= de_reg_write;
            if (alu_upd) flags <= alu_flags;
        end else begin
            xm_valid     <= 1'b0;
            xm_reg_write <= 1'b0;
        end
    end

endmodule

// File: doc/execute_stage_pipe.md
Name: execute_stage_pipe

Overview:
Parametrised execute stage for the pipelined processor. It includes operand forwarding, an iterative multi-cycle multiplier with a stall handshake, and the X/M pipeline register. It sits between the D/E register and the memory stage. It drives the registered ALU result, destination and flags that feed the M stage and its own X-to-X forwarding path.

Parameters:
DATA_W, 16, datapath width in bits (even, >= 8)
REG_AW, 4, register-address width; register 0 is hardwired zero and is never a forwarding match
FLAG_W, 3, flag vector width {Z,V,N}; fixed at 3, present for interface symmetry

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
de_valid  in  1  D/E holds a real instruction
de_opcode  in  4  operation code
de_rs, de_rt, de_rd  in  REG_AW each  source and destination register numbers
de_reg1, de_reg2  in  DATA_W each  register-file read data
de_imm  in  DATA_W  sign/zero-extended immediate
de_alu_src  in  1  1: B operand = de_imm
de_reg_write  in  1  instruction writes rd
de_mem_op  in  1  load/store; forces A[0]=0 and opcode ADD
flush  in  1  synchronous kill of the current and in-flight instruction
mw_reg_write  in  1  M/W stage writes back
mw_rd  in  REG_AW  M/W destination
wb_data  in  DATA_W  M/W write-back value
stall  out  1  upstream must hold D/E unchanged
xm_valid  out  1  X/M register holds a real instruction
xm_result  out  DATA_W  registered ALU result
xm_rd  out  REG_AW  registered destination
xm_reg_write  out  1  registered write enable (0 when xm_valid=0)
flags  out  3  architectural flags {Z,V,N}, registered

Behaviour:
- Reset (rst_n low, async): xm_valid=0, xm_result=0, xm_rd=0, xm_reg_write=0, flags=3'b000, stall=0, FSM=IDLE, iteration counter=0.
- Forwarding for A (rs) and likewise B (rt):
  - X2X when xm_reg_write && xm_rd!=0 && xm_rd==rs; the source is xm_result.
  - Otherwise M2X when mw_reg_write && mw_rd!=0 && mw_rd==rs; the source is wb_data.
  - Otherwise de_reg1.
  - X2X has priority over M2X.
- B operand: de_imm when de_alu_src=1, else the forwarded rt value. de_mem_op forces ADD on A & ~1, with no saturation and no flag update.
- Opcodes:
  - 0 ADD, 1 SUB: signed saturating to +max/-min. Set Z, N and V; V=1 iff saturation occurred.
  - 2 XOR: sets Z only.
  - 4 SLL, 5 SRA, 6 ROR: amount is B[log2(DATA_W)-1:0]. Set Z only.
  - 7 MUL: low DATA_W bits of the unsigned product. Sets Z and N.
  - All others: result = B, no flag update.
- Flags update only at the edge where the producing instruction enters X/M with xm_valid=1.
- Single-cycle ops: if de_valid && !stall && !flush, the X/M registers load at the next edge (latency 1). Otherwise xm_valid=0 and xm_reg_write=0 (bubble).
- MUL FSM with states IDLE and BUSY:
  - IDLE->BUSY at an edge where de_valid && opcode==7 && !flush. That edge latches the forwarded operands, rd and reg_write, clears the accumulator and sets count=0. X/M gets a bubble.
  - In BUSY, stall=1 combinationally. Each edge performs one shift-add step and increments count.
  - In IDLE with a MUL presented, stall=1 in that same cycle, so D/E stays held while the latch happens. The D/E instruction is consumed at the BUSY->IDLE edge.
  - BUSY->IDLE at the edge where count==DATA_W-1. That edge writes the product to X/M with xm_valid=1, and stall drops in the following cycle.
  - Total: the accepting edge plus DATA_W edges. With DATA_W=16, the result is visible 17 cycles after acceptance.
  - In the cycle after completion, stall=0 and the next D/E instruction issues. Forwarding sees the MUL result via X2X.
- flush: the X/M register loads a bubble and BUSY->IDLE immediately with the product discarded. stall=0 in the next cycle. flush wins over a simultaneous de_valid.
- Reset during BUSY aborts the multiply with no output.
- de_valid=0 while IDLE: bubble, no flag change.

Test Plan:
- ADD forwarding: xm_rd=3 (xm_result=0x0005, xm_reg_write=1), mw_rd=3 (wb_data=0x0009), ADD rs=3, rt=0 reg2=0x0002 -> X2X wins; next-cycle xm_result=0x0007, flags Z=0,V=0,N=0.
- Saturation: ADD 0x7FFF+0x0001 -> xm_result=0x7FFF, V=1, N=0. SUB 0x8000-0x0001 -> 0x8000, V=1, N=1.
- MUL 0x0013*0x0021 (DATA_W=16): stall high for exactly 17 cycles, xm_valid=0 during them. Then xm_result=0x0273, Z=0, N=0, and a dependent ADD forwards 0x0273.
- flush at the 5th cycle of a MUL -> stall=0 next cycle, no xm_valid pulse, flags unchanged. A following XOR 0xFFFF^0xFFFF gives 0x0000, Z=1.
- Register-0 guard: xm_rd=0 with xm_reg_write=1 and rs=0 -> A uses de_reg1, no forward. A mem op with A=0x1235 and imm=2 gives 0x1236, flags unchanged.
- Reset asserted async mid-BUSY -> all outputs zero immediately, stall=0. After release, ROR 0x8001 by 1 gives 0xC000, Z=0.
